fetch_stage: RTL and testbench

- Instruction Fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the Decode stage.
- Holds the PC and a word-addressed instruction ROM, plus the IF/ID pipeline register.
- Supplies Decode with Instruction and InputAddress (PC+4).
- Consumes Decode's PCSrc/NextAddress redirect and the hazard unit's Stall; adds a run/halt control FSM for simulation runs.

---
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with a constant instruction ROM,
// the IF/ID pipeline register and a RUN/HALT control FSM.
// The ROM image comes from IMEM_INIT rather than a load file, so its contents
// are fixed at elaboration.
//
// Ports:
//   Clk          in   pipeline clock, all state updates on posedge
//   Reset        in   asynchronous active-high reset
//   Stall        in   hazard-unit stall, holds PC and IF/ID
//   PCSrc        in   redirect request from Decode
//   NextAddress  in   redirect target from Decode
//   Instruction  out  IF/ID instruction (NOP when squashed)
//   InputAddress out  IF/ID PC+4 of Instruction
//   PC           out  current fetch address
//   FetchValid   out  IF/ID holds a real instruction
//   Halted       out  FSM is in HALT
//   Misaligned   out  sticky flag, a redirect target had bits [1:0] != 0
//   FetchCount   out  number of valid instructions loaded into IF/ID
module fetch_stage #(
   parameter int unsigned IMEM_DEPTH = 1024,
   parameter logic [31:0] IMEM_INIT [IMEM_DEPTH] = '{default: 32'h0},
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        PCSrc,
   input  logic [31:0] NextAddress,
   output logic [31:0] Instruction,
   output logic [31:0] InputAddress,
   output logic [31:0] PC,
   output logic        FetchValid,
   output logic        Halted,
   output logic        Misaligned,
   output logic [31:0] FetchCount
);

   localparam int unsigned AW = $clog2(IMEM_DEPTH);

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] iaddr_q, iaddr_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        mis_q, mis_d;
   logic [31:0] count_q, count_d;
   logic [31:0] word_c;

   // ROM read; word addresses past the end of the ROM read as NOP
   always_comb begin
      word_c = 32'h0;
      if ({2'b00, pc_q[31:2]} < IMEM_DEPTH) begin
         word_c = IMEM_INIT[pc_q[AW+1:2]];
      end
   end

   // Next-state logic. RUN priority: Stall > PCSrc > halt detect > normal fetch
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      iaddr_d  = iaddr_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      mis_d    = mis_q;
      count_d  = count_q;

      case (state_q)
         ST_RUN: begin
            if (Stall) begin
               // hold everything; Decode re-presents any redirect after the stall
            end else if (PCSrc) begin
               // squash the wrong-path fetch, there is no delay slot
               pc_d    = {NextAddress[31:2], 2'b00};
               instr_d = 32'h0;
               iaddr_d = 32'h0;
               valid_d = 1'b0;
               if (NextAddress[1:0] != 2'b00) begin
                  mis_d = 1'b1;
               end
            end else if (word_c == HALT_WORD) begin
               instr_d  = 32'h0;
               iaddr_d  = 32'h0;
               valid_d  = 1'b0;
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               instr_d = word_c;
               iaddr_d = pc_q + 32'd4;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
               count_d = count_q + 32'd1;
            end
         end
         ST_HALT: begin
            // keep feeding bubbles so the downstream pipeline drains
            instr_d = 32'h0;
            iaddr_d = 32'h0;
            valid_d = 1'b0;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         instr_q  <= 32'h0;
         iaddr_q  <= 32'h0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         mis_q    <= 1'b0;
         count_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         iaddr_q  <= iaddr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         mis_q    <= mis_d;
         count_q  <= count_d;
      end
   end

   assign Instruction  = instr_q;
   assign InputAddress = iaddr_q;
   assign PC           = pc_q;
   assign FetchValid   = valid_q;
   assign Halted       = halted_q;
   assign Misaligned   = mis_q;
   assign FetchCount   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test of fetch_stage with a 32-word ROM image.
// Inputs change 1 time unit after a posedge, and outputs are sampled there too.
module tb_fetch_stage;

   localparam logic [31:0] ROM_IMG [32] = '{
      0:  32'h2008_0005,
      1:  32'h2009_0007,
      2:  32'h0109_5020,
      3:  32'h0000_0000,
      4:  32'h214A_0001,
      5:  32'hFFFF_FFFF,
      16: 32'h8C0B_0000,
      17: 32'hAC0B_0004,
      default: 32'h0
   };

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Stall = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] NextAddress = 32'h0;
   logic [31:0] Instruction;
   logic [31:0] InputAddress;
   logic [31:0] PC;
   logic        FetchValid;
   logic        Halted;
   logic        Misaligned;
   logic [31:0] FetchCount;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_stage #(
      .IMEM_DEPTH (32),
      .IMEM_INIT  (ROM_IMG),
      .RESET_PC   (32'h0000_0000),
      .HALT_WORD  (32'hFFFF_FFFF)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Stall        (Stall),
      .PCSrc        (PCSrc),
      .NextAddress  (NextAddress),
      .Instruction  (Instruction),
      .InputAddress (InputAddress),
      .PC           (PC),
      .FetchValid   (FetchValid),
      .Halted       (Halted),
      .Misaligned   (Misaligned),
      .FetchCount   (FetchCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare the full output set against expected values
   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                          input logic [31:0] e_ia, input logic e_fv, input logic [31:0] e_fc,
                          input logic e_halt, input logic e_mis);
      chk({tag, ".pc"},    PC,                   e_pc);
      chk({tag, ".instr"}, Instruction,          e_ins);
      chk({tag, ".iaddr"}, InputAddress,         e_ia);
      chk({tag, ".valid"}, 32'(FetchValid),      32'(e_fv));
      chk({tag, ".count"}, FetchCount,           e_fc);
      chk({tag, ".halted"},32'(Halted),          32'(e_halt));
      chk({tag, ".mis"},   32'(Misaligned),      32'(e_mis));
   endtask

   // Apply inputs, then advance one posedge
   task automatic step(input logic s, input logic p, input logic [31:0] na);
      Stall       = s;
      PCSrc       = p;
      NextAddress = na;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge Clk);
      #1;
      chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
      Reset = 1'b0;

      // straight-line fetch
      step(1'b0, 1'b0, 32'h0);
      chk_all("fetch0", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      chk_all("fetch4", 32'h8, 32'h2009_0007, 32'h8, 1'b1, 32'd2, 1'b0, 1'b0);

      // stall holds everything, and a simultaneous PCSrc is ignored
      step(1'b1, 1'b1, 32'h40);
      chk_all("stall1", 32'h8, 32'h2009_0007, 32'h8, 1'b1, 32'd2, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0);
      chk_all("stall2", 32'h8, 32'h2009_0007, 32'h8, 1'b1, 32'd2, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      chk_all("fetch8", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 32'd3, 1'b0, 1'b0);

      // redirect from PC=12 to 0x40: one bubble, then ROM[16]
      step(1'b0, 1'b1, 32'h40);
      chk_all("redir40", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      chk_all("fetch40", 32'h44, 32'h8C0B_0000, 32'h44, 1'b1, 32'd4, 1'b0, 1'b0);

      // stall wins over PCSrc, redirect takes effect once stall drops
      step(1'b1, 1'b1, 32'h8);
      chk_all("stredir", 32'h44, 32'h8C0B_0000, 32'h44, 1'b1, 32'd4, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h8);
      chk_all("redir08", 32'h8, 32'h0, 32'h0, 1'b0, 32'd4, 1'b0, 1'b0);

      // misaligned target is rounded down and flagged stickily
      step(1'b0, 1'b1, 32'h42);
      chk_all("mis42", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0);
      chk_all("misfetch", 32'h44, 32'h8C0B_0000, 32'h44, 1'b1, 32'd5, 1'b0, 1'b1);

      // address past the end of the ROM reads as NOP but is still a valid fetch
      step(1'b0, 1'b1, 32'h80);
      chk_all("redir80", 32'h80, 32'h0, 32'h0, 1'b0, 32'd5, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0);
      chk_all("oob80", 32'h84, 32'h0, 32'h84, 1'b1, 32'd6, 1'b0, 1'b1);

      // PC wraps at 2^32
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      chk_all("redirtop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd6, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0);
      chk_all("wrap", 32'h0, 32'h0, 32'h0, 1'b1, 32'd7, 1'b0, 1'b1);

      // HALT_WORD fetched together with PCSrc is squashed and does not halt
      step(1'b0, 1'b1, 32'h14);
      chk_all("redir14", 32'h14, 32'h0, 32'h0, 1'b0, 32'd7, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'hC);
      chk_all("nohalt", 32'hC, 32'h0, 32'h0, 1'b0, 32'd7, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0);
      chk_all("fetchC", 32'h10, 32'h0, 32'h10, 1'b1, 32'd8, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0);
      chk_all("fetch10", 32'h14, 32'h214A_0001, 32'h14, 1'b1, 32'd9, 1'b0, 1'b1);

      // HALT_WORD at PC=0x14 halts; PC holds and bubbles flow
      step(1'b0, 1'b0, 32'h0);
      chk_all("halt", 32'h14, 32'h0, 32'h0, 1'b0, 32'd9, 1'b1, 1'b1);
      step(1'b1, 1'b1, 32'h40);
      chk_all("haltst", 32'h14, 32'h0, 32'h0, 1'b0, 32'd9, 1'b1, 1'b1);
      step(1'b0, 1'b1, 32'h40);
      chk_all("haltpc", 32'h14, 32'h0, 32'h0, 1'b0, 32'd9, 1'b1, 1'b1);
      step(1'b0, 1'b0, 32'h0);
      chk_all("haltrun", 32'h14, 32'h0, 32'h0, 1'b0, 32'd9, 1'b1, 1'b1);

      // asynchronous reset out of HALT, mid-cycle
      Stall = 1'b0;
      PCSrc = 1'b0;
      #1;
      Reset = 1'b1;
      #1;
      chk_all("arst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
      Reset = 1'b0;
      step(1'b0, 1'b0, 32'h0);
      chk_all("restart", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
